// File: rtl/cmp_dec_pkg.sv
// rtl/cmp_dec_pkg.sv - shared types, constants and window helper for cmp_decimator
package cmp_dec_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    ACC   = 1'b1
  } state_t;

  localparam int WIN_BASE_LOG2 = 5;
  localparam int CNT_W_DEF     = 8;
  // wcnt must reach the longest window minus one (256 - 1)
  localparam int WCNT_W        = WIN_BASE_LOG2 + 3;

  // Window length in cycles for a 2-bit selector: 32, 64, 128 or 256
  function automatic logic [WCNT_W:0] win_len(input logic [1:0] sel);
    return (WCNT_W+1)'(1 << (WIN_BASE_LOG2 + int'(sel)));
  endfunction

endpackage

// File: rtl/cmp_decimator_if.sv
// rtl/cmp_decimator_if.sv - control, comparator and result signals of cmp_decimator
interface cmp_decimator_if
  import cmp_dec_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             ena;
  logic             cmp_in;
  logic [1:0]       win_sel;
  logic             out_sel;
  logic             hold;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             cmp_sync;

  modport master (
    output ena, cmp_in, win_sel, out_sel, hold,
    input  result, result_valid, cmp_sync
  );

  modport slave (
    input  ena, cmp_in, win_sel, out_sel, hold,
    output result, result_valid, cmp_sync
  );

endinterface

// File: rtl/cmp_sync.sv
// rtl/cmp_sync.sv - enable-gated multi-flop synchronizer for an async comparator tap
module cmp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the async level through the flop chain; frozen while disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= '0;
    end else if (ena) begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/cmp_decimator.sv
// rtl/cmp_decimator.sv - windowed ones/toggle counter for a synchronized comparator output
module cmp_decimator
  import cmp_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  cmp_decimator_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  logic              s;
  logic              s_prev;
  logic [1:0]        prime_cnt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W:0]   win_len_q;
  logic [CNT_W:0]    ones;
  logic [CNT_W:0]    tog;
  logic [CNT_W:0]    ones_nx;
  logic [CNT_W:0]    tog_nx;
  logic [CNT_W-1:0]  cap_ones;
  logic [CNT_W-1:0]  cap_tog;
  logic              valid_q;
  logic              prime_last;
  logic              last_cyc;
  logic              acc_en;
  logic              prime_exit;
  logic              boundary;

  // Clamp a widened accumulator to the result width
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] x);
    return x[CNT_W] ? '1 : x[CNT_W-1:0];
  endfunction

  cmp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (bus.ena),
    .d     (bus.cmp_in),
    .q     (s)
  );

  assign prime_last = (prime_cnt == 2'(SYNC_STAGES - 1));
  assign last_cyc   = ({1'b0, wcnt} == (win_len_q - (WCNT_W+1)'(1)));
  assign ones_nx    = (&ones) ? ones : ones + (CNT_W+1)'(s);
  assign tog_nx     = (&tog)  ? tog  : tog  + (CNT_W+1)'(s != s_prev);

  // FSM state register; PRIME only advances on enabled cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PRIME;
    end else if (bus.ena) begin
      state <= state_nx;
    end
  end

  // Next state: leave PRIME on its last enabled cycle, ACC is terminal
  always_comb begin
    state_nx = state;
    if (state == PRIME && prime_last) begin
      state_nx = ACC;
    end
  end

  // FSM decoded strobes for the datapath
  always_comb begin
    acc_en     = 1'b0;
    prime_exit = 1'b0;
    boundary   = 1'b0;
    case (state)
      PRIME:   prime_exit = bus.ena && prime_last;
      ACC: begin
        acc_en   = bus.ena;
        boundary = bus.ena && last_cyc;
      end
      default: ;
    endcase
  end

  // Count PRIME cycles and track the previous synchronized level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prime_cnt <= '0;
      s_prev    <= 1'b0;
    end else if (bus.ena) begin
      s_prev <= s;
      if (state == PRIME) begin
        prime_cnt <= prime_cnt + 2'd1;
      end
    end
  end

  // Window length is latched only at window starts so mid-window changes wait
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_len_q <= win_len(2'd0);
    end else if (prime_exit || boundary) begin
      win_len_q <= win_len(bus.win_sel);
    end
  end

  // Accumulate the current window; a boundary starts the next one with no gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones <= '0;
      tog  <= '0;
      wcnt <= '0;
    end else if (acc_en) begin
      if (boundary) begin
        ones <= '0;
        tog  <= '0;
        wcnt <= '0;
      end else begin
        ones <= ones_nx;
        tog  <= tog_nx;
        wcnt <= wcnt + WCNT_W'(1);
      end
    end
  end

  // Capture the finished window including its final sample unless held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_ones <= '0;
      cap_tog  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= boundary && !bus.hold;
      if (boundary && !bus.hold) begin
        cap_ones <= sat(ones_nx);
        cap_tog  <= sat(tog_nx);
      end
    end
  end

  assign bus.result       = bus.out_sel ? cap_tog : cap_ones;
  assign bus.result_valid = valid_q;
  assign bus.cmp_sync     = s;

endmodule

// File: tb/tb_cmp_decimator.sv
// tb/tb_cmp_decimator.sv - randomized self-checking bench for cmp_decimator
module tb_cmp_decimator;
  import cmp_dec_pkg::*;

  localparam int SS   = 2;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cmp_decimator_if #(.CNT_W(W)) bus ();

  cmp_decimator #(.SYNC_STAGES(SS), .CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: history of samples taken on enabled edges, windows as index ranges
  bit hist[$];
  int en_idx;
  int win_start;
  int win_len_m;
  int m_ones;
  int m_tog;
  int cyc;
  bit m_valid;
  bit m_sync;

  // Synchronized level seen by the counters on enabled edge j
  function automatic bit s_at(int j);
    if (j < SS || (j - SS) >= hist.size()) return 1'b0;
    return hist[j - SS];
  endfunction

  function automatic int exp_result();
    return bus.out_sel ? m_tog : m_ones;
  endfunction

  task automatic model_edge();
    int j;
    int o;
    int t;
    if (!rst_n) begin
      hist.delete();
      en_idx    = 0;
      win_start = 32'h3fff_0000;
      win_len_m = 32;
      m_ones    = 0;
      m_tog     = 0;
      m_valid   = 1'b0;
      m_sync    = 1'b0;
      cyc       = 0;
      return;
    end
    cyc++;
    m_valid = 1'b0;
    if (!bus.ena) return;
    j = en_idx;
    hist.push_back(bus.cmp_in);
    if (j == SS - 1) begin
      win_start = SS;
      win_len_m = 32 << bus.win_sel;
    end else if (j >= SS && j == win_start + win_len_m - 1) begin
      o = 0;
      t = 0;
      for (int k = win_start; k <= j; k++) begin
        o += int'(s_at(k));
        t += int'(s_at(k) != s_at(k - 1));
      end
      if (!bus.hold) begin
        m_ones  = (o > MAXV) ? MAXV : o;
        m_tog   = (t > MAXV) ? MAXV : t;
        m_valid = 1'b1;
      end
      win_start = j + 1;
      win_len_m = 32 << bus.win_sel;
    end
    en_idx++;
    m_sync = s_at(en_idx);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.cmp_in  = 1'b0;
    bus.win_sel = 2'd0;
    bus.out_sel = 1'b0;
    bus.hold    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.ena     = 1'b1;
    bus.cmp_in  = 1'b1;
    bus.win_sel = 2'd0;
    bus.out_sel = 1'b0;
    bus.hold    = 1'b0;
    rst_n       = 1'b0;
    tick();
    checks++;
    if (bus.result !== 8'd0) begin
      errors++; $display("FAIL reset_result got %0d exp 0", bus.result);
    end
    checks++;
    if (bus.result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b exp 0", bus.result_valid);
    end
    checks++;
    if (bus.cmp_sync !== 1'b0) begin
      errors++; $display("FAIL reset_sync got %0b exp 0", bus.cmp_sync);
    end
  endtask

  task automatic test_constant_ones();
    int first;
    int nvalid;
    do_reset();
    bus.cmp_in = 1'b1;
    first  = 0;
    nvalid = 0;
    for (int i = 0; i < 98; i++) begin
      tick();
      checks++;
      if (bus.result_valid !== m_valid) begin
        errors++; $display("FAIL const_valid cyc %0d got %0b exp %0b", cyc, bus.result_valid, m_valid);
      end
      if (bus.result_valid) begin
        nvalid++;
        if (first == 0) first = cyc;
      end
    end
    checks++;
    if (first != 34) begin
      errors++; $display("FAIL const_first_valid got cycle %0d exp 34", first);
    end
    checks++;
    if (nvalid != 3) begin
      errors++; $display("FAIL const_valid_count got %0d exp 3", nvalid);
    end
    checks++;
    if (bus.result !== 8'd32) begin
      errors++; $display("FAIL const_ones got %0d exp 32", bus.result);
    end
    bus.out_sel = 1'b1;
    #1;
    checks++;
    if (bus.result !== 8'd0) begin
      errors++; $display("FAIL const_toggles got %0d exp 0", bus.result);
    end
    bus.out_sel = 1'b0;
  endtask

  task automatic test_alternating();
    do_reset();
    bus.cmp_in = 1'b1;
    for (int i = 0; i < 34; i++) begin
      tick();
      bus.cmp_in = ~bus.cmp_in;
    end
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL alt_valid got %0b exp 1", bus.result_valid);
    end
    checks++;
    if (bus.result !== 8'd16) begin
      errors++; $display("FAIL alt_ones got %0d exp 16", bus.result);
    end
    bus.out_sel = 1'b1;
    #1;
    checks++;
    if (bus.result !== 8'd32) begin
      errors++; $display("FAIL alt_toggles_same_cycle got %0d exp 32", bus.result);
    end
    bus.out_sel = 1'b0;
  endtask

  task automatic test_saturation_winchange();
    bit exp_v;
    do_reset();
    bus.cmp_in  = 1'b1;
    bus.win_sel = 2'd3;
    for (int i = 0; i < 292; i++) begin
      tick();
      if (cyc == 100) bus.win_sel = 2'd0;
      exp_v = (cyc == 258 || cyc == 290);
      checks++;
      if (bus.result_valid !== exp_v) begin
        errors++; $display("FAIL sat_valid cyc %0d got %0b exp %0b", cyc, bus.result_valid, exp_v);
      end
      if (cyc == 258) begin
        checks++;
        if (bus.result !== 8'd255) begin
          errors++; $display("FAIL sat_ones got %0d exp 255", bus.result);
        end
      end
      if (cyc == 290) begin
        checks++;
        if (bus.result !== 8'd32) begin
          errors++; $display("FAIL short_window_ones got %0d exp 32", bus.result);
        end
      end
    end
  endtask

  task automatic test_hold();
    int nvalid;
    do_reset();
    nvalid = 0;
    for (int i = 0; i < 120; i++) begin
      bus.cmp_in = 1'($urandom_range(0, 1));
      tick();
      if (cyc == 50) bus.hold = 1'b1;
      if (cyc == 70) bus.hold = 1'b0;
      if (bus.result_valid) nvalid++;
      checks++;
      if (bus.result_valid !== m_valid) begin
        errors++; $display("FAIL hold_valid cyc %0d got %0b exp %0b", cyc, bus.result_valid, m_valid);
      end
      checks++;
      if (bus.result !== 8'(exp_result())) begin
        errors++; $display("FAIL hold_result cyc %0d got %0d exp %0d", cyc, bus.result, exp_result());
      end
    end
    checks++;
    if (nvalid != 2) begin
      errors++; $display("FAIL hold_valid_count got %0d exp 2", nvalid);
    end
  endtask

  task automatic test_ena_gap();
    bit exp_v;
    do_reset();
    bus.cmp_in = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == 15) bus.ena = 1'b0;
      if (cyc == 25) bus.ena = 1'b1;
      exp_v = (cyc == 44);
      checks++;
      if (bus.result_valid !== exp_v) begin
        errors++; $display("FAIL ena_gap_valid cyc %0d got %0b exp %0b", cyc, bus.result_valid, exp_v);
      end
      if (cyc == 44) begin
        checks++;
        if (bus.result !== 8'd32) begin
          errors++; $display("FAIL ena_gap_ones got %0d exp 32", bus.result);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit exp_v;
    do_reset();
    bus.cmp_in = 1'b1;
    while (cyc < 54) tick();
    checks++;
    if (bus.result !== 8'd32) begin
      errors++; $display("FAIL mid_pre_reset_result got %0d exp 32", bus.result);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.result !== 8'd0 || bus.result_valid !== 1'b0 || bus.cmp_sync !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs got %0d/%0b/%0b exp 0/0/0", bus.result, bus.result_valid, bus.cmp_sync);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.cmp_in = 1'($urandom_range(0, 1));
      tick();
      exp_v = (cyc == 34);
      checks++;
      if (bus.result_valid !== exp_v) begin
        errors++; $display("FAIL mid_restart_valid cyc %0d got %0b exp %0b", cyc, bus.result_valid, exp_v);
      end
      checks++;
      if (bus.result !== 8'(exp_result())) begin
        errors++; $display("FAIL mid_restart_result cyc %0d got %0d exp %0d", cyc, bus.result, exp_result());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.cmp_in = ($urandom_range(0, 3) == 0) ? ~bus.cmp_in : 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (bus.result_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", cyc, bus.result_valid, m_valid);
      end
      checks++;
      if (bus.result !== 8'(exp_result())) begin
        errors++; $display("FAIL rand_result cyc %0d got %0d exp %0d", cyc, bus.result, exp_result());
      end
      checks++;
      if (bus.cmp_sync !== m_sync) begin
        errors++; $display("FAIL rand_sync cyc %0d got %0b exp %0b", cyc, bus.cmp_sync, m_sync);
      end
      rst_n       = ($urandom_range(0, 599) != 0);
      bus.ena     = ($urandom_range(0, 7) != 0);
      bus.out_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 47) == 0) bus.hold = ~bus.hold;
      if ($urandom_range(0, 19) == 0) bus.win_sel = 2'($urandom_range(0, 1) + (($urandom_range(0, 9) == 0) ? 2 : 0));
    end
  endtask

  initial begin
    test_reset();
    test_constant_ones();
    test_alternating();
    test_saturation_winchange();
    test_hold();
    test_ena_gap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
